// File: rtl/counter_xn_pkg.sv
// rtl/counter_xn_pkg.sv - shared register map, CTRL layout and mode codes for counter_xn
package counter_xn_pkg;

    // Register select codes on counter_sel
    localparam logic [1:0] SEL_LOAD   = 2'd0;
    localparam logic [1:0] SEL_CTRL   = 2'd1;
    localparam logic [1:0] SEL_COUNT  = 2'd2;
    localparam logic [1:0] SEL_STATUS = 2'd3;

    // CTRL register bit positions
    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_SRC     = 3;
    localparam int CTRL_IRQ_EN  = 4;
    localparam int CTRL_W       = 5;

    // Counting modes; the reserved code behaves as one-shot
    typedef enum logic [1:0] {
        MODE_ONESHOT  = 2'd0,
        MODE_PERIODIC = 2'd1,
        MODE_FREERUN  = 2'd2,
        MODE_RSVD     = 2'd3
    } mode_e;

endpackage

// File: rtl/counter_xn_chan.sv
// rtl/counter_xn_chan.sv - one down-counter channel: LOAD/COUNT/CTRL/STATUS, tick sync and decrement
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   tick_in               raw external tick, asynchronous to clk
//   load_we/ctrl_we/clear_we  decoded write strobes for this channel
//   wdata                 32-bit write data
//   load, count, ctrl     register contents
//   expired               sticky expiry status
module counter_xn_chan
    import counter_xn_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              tick_in,
    input  logic              load_we,
    input  logic              ctrl_we,
    input  logic              clear_we,
    input  logic [31:0]       wdata,
    output logic [WIDTH-1:0]  load,
    output logic [WIDTH-1:0]  count,
    output logic [CTRL_W-1:0] ctrl,
    output logic              expired
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    // [0],[1] synchroniser flops, [2] previous synchronised level for edge detect.
    // The edge is decoded from registered state, so the decrement lands on the
    // third clk edge after the tick_in rise.
    logic [2:0]  sync_q;
    logic        tick_edge;
    logic        tick;
    logic        active;
    mode_e       mode;
    logic [WIDTH-1:0] count_nxt;
    logic        expire;
    logic        disarm;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync_q <= '0;
        else          sync_q <= {sync_q[1:0], tick_in};
    end

    assign tick_edge = sync_q[1] & ~sync_q[2];
    assign tick      = ctrl[CTRL_SRC] ? tick_edge : 1'b1;
    // A LOAD write overrides any tick in the same cycle
    assign active    = ctrl[CTRL_EN] & tick & ~load_we;
    assign mode      = mode_e'(ctrl[CTRL_MODE_LO +: 2]);

    always_comb begin
        count_nxt = count;
        expire    = 1'b0;
        disarm    = 1'b0;
        if (active) begin
            case (mode)
                MODE_PERIODIC: begin
                    if (count > ONE) begin
                        count_nxt = count - ONE;
                    end else if (count == ONE) begin
                        count_nxt = load;
                        expire    = 1'b1;
                    end
                end
                MODE_FREERUN: begin
                    count_nxt = count - ONE;
                    expire    = (count == '0);
                end
                default: begin
                    if (count > ONE) begin
                        count_nxt = count - ONE;
                    end else if (count == ONE) begin
                        count_nxt = '0;
                        expire    = 1'b1;
                        disarm    = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            load    <= '0;
            count   <= '0;
            ctrl    <= '0;
            expired <= 1'b0;
        end else begin
            if (load_we) begin
                load  <= wdata[WIDTH-1:0];
                count <= wdata[WIDTH-1:0];
            end else begin
                count <= count_nxt;
            end

            if (ctrl_we)     ctrl          <= wdata[CTRL_W-1:0];
            else if (disarm) ctrl[CTRL_EN] <= 1'b0;

            // A new expiry outranks a same-cycle W1C
            if (expire)                     expired <= 1'b1;
            else if (clear_we && wdata[0])  expired <= 1'b0;
        end
    end

endmodule

// File: rtl/counter_xn.sv
// rtl/counter_xn.sv - NCH-channel down-counter/timer peripheral with register port and OR-ed irq
//
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   tick_in        per-channel external tick sources (asynchronous)
//   counter_we     write strobe
//   counter_ch     channel select; channels >= NCH read 0 and ignore writes
//   counter_sel    register select (LOAD, CTRL, COUNT, STATUS)
//   counter_val    write data
//   counter_out    registered read data, zero-extended
//   counter_zero   per-channel COUNT == 0
//   counter_irq    OR of expired & irq_en over channels
module counter_xn
    import counter_xn_pkg::*;
#(
    parameter int NCH   = 3,
    parameter int WIDTH = 32,
    parameter int CH_W  = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [NCH-1:0]  tick_in,
    input  logic            counter_we,
    input  logic [CH_W-1:0] counter_ch,
    input  logic [1:0]      counter_sel,
    input  logic [31:0]     counter_val,
    output logic [31:0]     counter_out,
    output logic [NCH-1:0]  counter_zero,
    output logic            counter_irq
);

    logic [WIDTH-1:0]  load_a    [NCH];
    logic [WIDTH-1:0]  count_a   [NCH];
    logic [CTRL_W-1:0] ctrl_a    [NCH];
    logic [NCH-1:0]    expired_a;
    logic [NCH-1:0]    irq_bits;
    logic [31:0]       rd_data;

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        // Channel match only exists for i < NCH, so out-of-range selects hit nothing
        logic hit;
        assign hit = counter_we && (counter_ch == CH_W'(i));

        counter_xn_chan #(.WIDTH(WIDTH)) u_chan (
            .clk      (clk),
            .reset_n  (reset_n),
            .tick_in  (tick_in[i]),
            .load_we  (hit && (counter_sel == SEL_LOAD)),
            .ctrl_we  (hit && (counter_sel == SEL_CTRL)),
            .clear_we (hit && (counter_sel == SEL_STATUS)),
            .wdata    (counter_val),
            .load     (load_a[i]),
            .count    (count_a[i]),
            .ctrl     (ctrl_a[i]),
            .expired  (expired_a[i])
        );

        assign counter_zero[i] = (count_a[i] == '0);
        assign irq_bits[i]     = expired_a[i] & ctrl_a[i][CTRL_IRQ_EN];
    end

    assign counter_irq = |irq_bits;

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NCH; i++) begin
            if (counter_ch == CH_W'(i)) begin
                case (counter_sel)
                    SEL_LOAD:  rd_data[WIDTH-1:0]  = load_a[i];
                    SEL_CTRL:  rd_data[CTRL_W-1:0] = ctrl_a[i];
                    SEL_COUNT: rd_data[WIDTH-1:0]  = count_a[i];
                    default:   rd_data[0]          = expired_a[i];
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) counter_out <= '0;
        else          counter_out <= rd_data;
    end

endmodule
